// File: rtl/harmonica_rb_pkg.sv
// Shared types and constants for the register writeback stage.
// A writeback entry is one completed per-lane result headed for register_block.
package harmonica_rb_pkg;

    localparam int DATA_W    = 64;
    localparam int NUM_LANES = 8;
    localparam int REG_AW    = 4;
    localparam int WARP_W    = 3;
    localparam int NUM_SRC   = 2;
    localparam int CNT_W     = 16;

    localparam logic [CNT_W-1:0] CONFLICT_MAX = '1;

    // Lane i of data is data[i], i.e. bits [64i+63:64i] of the flattened bus.
    typedef struct packed {
        logic [WARP_W-1:0]                    warp;
        logic [REG_AW-1:0]                    rd;
        logic [NUM_LANES-1:0]                 mask;
        logic [NUM_LANES-1:0][DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding buffer for a single writeback source.
// A load in the same cycle as a clear wins, so a draining slot can refill without a bubble.
module wb_hold_slot
    import harmonica_rb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      clear,
    input  wb_entry_t entry_in,
    output logic      full,
    output wb_entry_t entry
);

    logic      full_reg;
    wb_entry_t entry_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_reg  <= 1'b0;
            entry_reg <= '0;
        end else if (load) begin
            full_reg  <= 1'b1;
            entry_reg <= entry_in;
        end else if (clear) begin
            full_reg  <= 1'b0;
        end
    end

    assign full  = full_reg;
    assign entry = entry_reg;

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: buffers one ALU and one LSU result, arbitrates round-robin
// and issues at most one registered write per cycle into register_block.
module register_writeback
    import harmonica_rb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [WARP_W-1:0]           alu_warp,
    input  logic [REG_AW-1:0]           alu_rd,
    input  logic [NUM_LANES-1:0]        alu_mask,
    input  logic [NUM_LANES*DATA_W-1:0] alu_data,

    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [WARP_W-1:0]           lsu_warp,
    input  logic [REG_AW-1:0]           lsu_rd,
    input  logic [NUM_LANES-1:0]        lsu_mask,
    input  logic [NUM_LANES*DATA_W-1:0] lsu_data,

    input  logic                        wb_stall,

    output logic [NUM_LANES-1:0]        write_en,
    output logic [REG_AW-1:0]           waddr,
    output logic [WARP_W-1:0]           wb_warp,
    output logic [DATA_W-1:0]           wdata_0,
    output logic [DATA_W-1:0]           wdata_1,
    output logic [DATA_W-1:0]           wdata_2,
    output logic [DATA_W-1:0]           wdata_3,
    output logic [DATA_W-1:0]           wdata_4,
    output logic [DATA_W-1:0]           wdata_5,
    output logic [DATA_W-1:0]           wdata_6,
    output logic [DATA_W-1:0]           wdata_7,
    output logic [CNT_W-1:0]            wb_conflict_cnt
);

    // Index 0 is the ALU, index 1 the LSU, matching wb_src_e.
    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] grant;
    wb_entry_t          slot_in  [NUM_SRC];
    wb_entry_t          slot_out [NUM_SRC];

    wb_entry_t          win_entry;
    wb_src_e            win_src;
    logic               any_grant;
    logic               conflict;

    logic [NUM_LANES-1:0]             write_en_reg;
    logic [REG_AW-1:0]                waddr_reg;
    logic [WARP_W-1:0]                wb_warp_reg;
    logic [NUM_LANES-1:0][DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]                 conflict_cnt_reg;
    wb_src_e                          last_grant_reg;

    assign src_valid  = {lsu_valid, alu_valid};
    assign slot_in[0] = {alu_warp, alu_rd, alu_mask, alu_data};
    assign slot_in[1] = {lsu_warp, lsu_rd, lsu_mask, lsu_data};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            // Ready reads high through reset, but nothing is captured until rst_n releases.
            assign src_ready[gi] = !rst_n || !full[gi] || grant[gi];
            assign accept[gi]    = rst_n && src_valid[gi] && src_ready[gi];

            wb_hold_slot u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (accept[gi]),
                .clear    (grant[gi]),
                .entry_in (slot_in[gi]),
                .full     (full[gi]),
                .entry    (slot_out[gi])
            );
        end
    endgenerate

    assign alu_ready = src_ready[0];
    assign lsu_ready = src_ready[1];

    // Round-robin: on a tie the source that did not win last gets the port.
    always_comb begin
        grant = '0;
        if (!wb_stall) begin
            if (&full) begin
                if (last_grant_reg == WB_SRC_LSU) begin
                    grant[0] = 1'b1;
                end else begin
                    grant[1] = 1'b1;
                end
            end else begin
                grant = full;
            end
        end
    end

    assign any_grant = |grant;
    assign win_src   = grant[1] ? WB_SRC_LSU : WB_SRC_ALU;
    assign win_entry = grant[1] ? slot_out[1] : slot_out[0];
    assign conflict  = (&full) && !wb_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_reg     <= '0;
            waddr_reg        <= '0;
            wb_warp_reg      <= '0;
            wdata_reg        <= '0;
            conflict_cnt_reg <= '0;
            last_grant_reg   <= WB_SRC_LSU;
        end else begin
            write_en_reg <= '0;
            if (any_grant) begin
                write_en_reg <= win_entry.mask;
                waddr_reg    <= win_entry.rd;
                wb_warp_reg  <= win_entry.warp;
                wdata_reg    <= win_entry.data;
                // An empty-mask entry is drained without costing its source a turn.
                if (win_entry.mask != '0) begin
                    last_grant_reg <= win_src;
                end
            end
            if (conflict && (conflict_cnt_reg != CONFLICT_MAX)) begin
                conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
            end
        end
    end

    assign write_en        = write_en_reg;
    assign waddr           = waddr_reg;
    assign wb_warp         = wb_warp_reg;
    assign wb_conflict_cnt = conflict_cnt_reg;
    assign wdata_0         = wdata_reg[0];
    assign wdata_1         = wdata_reg[1];
    assign wdata_2         = wdata_reg[2];
    assign wdata_3         = wdata_reg[3];
    assign wdata_4         = wdata_reg[4];
    assign wdata_5         = wdata_reg[5];
    assign wdata_6         = wdata_reg[6];
    assign wdata_7         = wdata_reg[7];

endmodule
